// File: rtl/array_16_pkg.sv
// Shared constants and state encoding for the array_16 request/response front-end.
package array_16_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;
  localparam int MASK_W = 4;
  localparam int LANE_W = DATA_W / MASK_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QDEPTH = 2;
  localparam int QCNT_W = $clog2(QDEPTH + 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/array_16_resp_fifo.sv
// Count-based response FIFO; storage is unreset, pointers and count reset to empty.
module array_16_resp_fifo #(
  parameter int DEPTH_Q = 2,
  parameter int WIDTH   = 24,
  parameter int CNT_W   = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH_Q > 1) ? $clog2(DEPTH_Q) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH_Q];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok   = pop && (count != '0);
  assign valid    = (count != '0);
  assign pop_data = mem_q[rd_ptr];

  // Data storage: written on every push, no reset needed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr] <= push_data;
  end

  // Pointers wrap at DEPTH_Q; count tracks push/pop, a pop on empty is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH_Q - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= (rd_ptr == PTR_W'(DEPTH_Q - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/array_16_ctrl.sv
// Front-end for the 256x24 masked array macro: zero-fill after reset, then
// valid/ready reads and masked writes with a credit-limited response FIFO.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_INIT | zero-filling the macro, one address per cycle, requests held off
//  ST_RUN  | normal operation, terminal until the next reset
module array_16_ctrl
  import array_16_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [MASK_W-1:0] wr_req_mask,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              mem_R0_clk,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic              mem_W0_clk,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask
);

  state_e              state;
  logic [ADDR_W-1:0]   init_ptr;
  logic                init_arm;
  logic                inflight;
  logic                run;
  logic                rd_accept;
  logic [QCNT_W-1:0]   fifo_count;
  logic [QCNT_W:0]     credit_used;

  // init_arm holds off the first fill write until one clock after reset
  // release, so every enable output is low while reset is asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      init_arm <= 1'b0;
    end else begin
      init_arm <= 1'b1;
      if (state == ST_INIT && init_arm) begin
        init_ptr <= init_ptr + ADDR_W'(1);
        if (init_ptr == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
      end
    end
  end

  // A read accepted this cycle has its data on mem_R0_data next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= rd_accept;
  end

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Credit only looks at registered count and inflight, never rd_resp_ready.
  assign credit_used  = {1'b0, fifo_count} + (QCNT_W + 1)'(inflight);
  assign rd_req_ready = run && (credit_used < (QCNT_W + 1)'(QDEPTH));
  assign wr_req_ready = run;
  assign rd_accept    = rd_req_valid && rd_req_ready;

  assign mem_R0_clk  = clock;
  assign mem_W0_clk  = clock;
  assign mem_R0_en   = rd_accept;
  assign mem_R0_addr = rd_req_addr;

  // Write port is owned by the zero-fill during INIT, by requests in RUN.
  assign mem_W0_en   = run ? wr_req_valid : init_arm;
  assign mem_W0_addr = run ? wr_req_addr  : init_ptr;
  assign mem_W0_data = run ? wr_req_data  : '0;
  assign mem_W0_mask = run ? wr_req_mask  : '1;

  array_16_resp_fifo #(
    .DEPTH_Q (QDEPTH),
    .WIDTH   (DATA_W),
    .CNT_W   (QCNT_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (mem_R0_data),
    .pop       (rd_resp_ready),
    .pop_data  (rd_resp_data),
    .valid     (rd_resp_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_array_16_ctrl.sv
// Scoreboard bench for array_16_ctrl with a behavioural model of the macro.
module tb_array_16_ctrl;
  import array_16_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done;
  logic              rd_req_valid = 1'b0;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic              wr_req_valid = 1'b0;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr = '0;
  logic [DATA_W-1:0] wr_req_data = '0;
  logic [MASK_W-1:0] wr_req_mask = '0;
  logic              rd_resp_valid;
  logic              rd_resp_ready = 1'b1;
  logic [DATA_W-1:0] rd_resp_data;
  logic              mem_R0_clk;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [DATA_W-1:0] mem_R0_data = '0;
  logic              mem_W0_clk;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [DATA_W-1:0] mem_W0_data;
  logic [MASK_W-1:0] mem_W0_mask;

  int n_vec  = 0;
  int n_fail = 0;
  bit auto_exp = 1'b0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] macro_mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] rec_nv;
  logic [DATA_W-1:0] rec_rd;
  logic [DATA_W-1:0] hand [5] = '{24'h5A5A80, 24'hA5A581, 24'h0F0F82, 24'hF0F083, 24'h123484};

  always #5 clock = ~clock;

  array_16_ctrl dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .mem_R0_clk(mem_R0_clk), .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en),
    .mem_R0_data(mem_R0_data), .mem_W0_clk(mem_W0_clk), .mem_W0_addr(mem_W0_addr),
    .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data), .mem_W0_mask(mem_W0_mask)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int l = 0; l < MASK_W; l++)
      if (m[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Macro model: write-first on a same-address collision, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_W0_en) macro_mem[mem_W0_addr] <= merge(macro_mem[mem_W0_addr], mem_W0_data, mem_W0_mask);
    if (mem_R0_en)
      mem_R0_data <= (mem_W0_en && mem_W0_addr == mem_R0_addr)
                     ? merge(macro_mem[mem_R0_addr], mem_W0_data, mem_W0_mask)
                     : macro_mem[mem_R0_addr];
  end

  // Recorder and monitor: reference model update, port checks, scoreboard pop.
  always @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
    end else begin
      rec_nv = merge(ref_mem[wr_req_addr], wr_req_data, wr_req_mask);
      rec_rd = (wr_req_valid && wr_req_ready && wr_req_addr == rd_req_addr) ? rec_nv : ref_mem[rd_req_addr];
      if (wr_req_valid && wr_req_ready) ref_mem[wr_req_addr] <= rec_nv;
      if (init_done) begin
        chk("r0_en", {63'd0, mem_R0_en}, {63'd0, rd_req_valid && rd_req_ready});
        chk("w0_en", {63'd0, mem_W0_en}, {63'd0, wr_req_valid});
        if (mem_R0_en) chk("r0_addr", {56'd0, mem_R0_addr}, {56'd0, rd_req_addr});
        if (wr_req_valid)
          chk("w0_port", {28'd0, mem_W0_addr, mem_W0_data, mem_W0_mask},
                         {28'd0, wr_req_addr, wr_req_data, wr_req_mask});
      end
      if (auto_exp && rd_req_valid && rd_req_ready) exp_q.push_back(rec_rd);
      if (rd_resp_valid && rd_resp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", {40'd0, rd_resp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   chk("rd_resp", {40'd0, rd_resp_data}, {40'd0, exp_q.pop_front()});
      end
    end
  end

  // Called right after reset release; ends on the negedge where init_done is first seen.
  task automatic check_init();
    int nwr = 0, addr_err = 0, data_err = 0, rdy_err = 0, cyc = 0;
    bit last_255 = 1'b0, done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (init_done) done_seen = 1'b1;
      else begin
        if (rd_req_ready || wr_req_ready || mem_R0_en) rdy_err++;
        if (mem_W0_en) begin
          if (mem_W0_addr != 8'(nwr)) addr_err++;
          if (mem_W0_data != '0 || mem_W0_mask != 4'hF) data_err++;
          last_255 = (mem_W0_addr == 8'hFF);
          nwr++;
        end else last_255 = 1'b0;
      end
    end
    chk("init_done_seen", {63'd0, done_seen}, 64'd1);
    chk("init_writes", nwr, 256);
    chk("init_addr_err", addr_err, 0);
    chk("init_data_err", data_err, 0);
    chk("init_ready_low", rdy_err, 0);
    chk("init_done_after_255", {63'd0, last_255}, 64'd1);
  endtask

  // Called at posedge+1; holds the request until accepted, pushes the hand value.
  task automatic rd_wr(input bit rv, input logic [7:0] ra, input logic [23:0] rexp,
                       input bit wv, input logic [7:0] wa, input logic [23:0] wd, input logic [3:0] wm);
    int b = 0;
    rd_req_valid = rv; rd_req_addr = ra;
    wr_req_valid = wv; wr_req_addr = wa; wr_req_data = wd; wr_req_mask = wm;
    while (rv && !rd_req_ready && b < 50) begin @(posedge clock); #1; b++; end
    if (rv) begin
      chk("rd_accept_timeout", {63'd0, rd_req_ready}, 64'd1);
      if (rd_req_ready) exp_q.push_back(rexp);
    end
    @(posedge clock); #1;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 60) begin @(posedge clock); #1; b++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int idx, b;
    // Test 1: zero-fill after reset
    exp_q.delete();
    release_reset();
    check_init();
    @(posedge clock); #1;

    // Test 2: masked write then read
    rd_wr(0, 8'h00, 24'h0, 1, 8'h12, 24'hABCDEF, 4'b0101);
    rd_wr(1, 8'h12, 24'h03C02F, 0, 8'h00, 24'h0, 4'h0);
    drain();

    // Test 3: same-cycle write visible; capture-cycle write not visible
    rd_wr(1, 8'h40, 24'h111111, 1, 8'h40, 24'h111111, 4'hF);
    rd_wr(0, 8'h00, 24'h0, 1, 8'h40, 24'h222222, 4'hF);
    rd_wr(1, 8'h40, 24'h222222, 0, 8'h00, 24'h0, 4'h0);
    drain();

    // Boundaries: address 255 and a mask-0 write
    rd_wr(0, 8'h00, 24'h0, 1, 8'hFF, 24'h123456, 4'hF);
    rd_wr(0, 8'h00, 24'h0, 1, 8'hFF, 24'hFFFFFF, 4'h0);
    rd_wr(1, 8'hFF, 24'h123456, 0, 8'h00, 24'h0, 4'h0);
    drain();

    // Test 4: backpressure with back-to-back reads
    for (int i = 0; i < 5; i++) rd_wr(0, 8'h00, 24'h0, 1, 8'(8'h80 + i), hand[i], 4'hF);
    rd_resp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      rd_req_valid = 1'b1; rd_req_addr = 8'(8'h80 + idx);
      if (rd_req_ready) begin exp_q.push_back(hand[idx]); idx++; end
      @(posedge clock); #1;
    end
    chk("held_accepts", idx, 2);
    chk("held_ready_low", {63'd0, rd_req_ready}, 64'd0);
    rd_resp_ready = 1'b1;
    b = 0;
    while (idx < 5 && b < 40) begin
      rd_req_valid = 1'b1; rd_req_addr = 8'(8'h80 + idx);
      if (rd_req_ready) begin exp_q.push_back(hand[idx]); idx++; end
      @(posedge clock); #1; b++;
    end
    rd_req_valid = 1'b0;
    chk("release_accepts", idx, 5);
    drain();

    // Test 5a: reset with one response queued
    rd_resp_ready = 1'b0;
    rd_wr(1, 8'h40, 24'h222222, 0, 8'h00, 24'h0, 4'h0);
    b = 0;
    while (!rd_resp_valid && b < 10) begin @(posedge clock); #1; b++; end
    chk("queued_before_reset", {63'd0, rd_resp_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("resp_valid_in_reset", {63'd0, rd_resp_valid}, 64'd0);
    chk("ready_in_reset", {62'd0, rd_req_ready, wr_req_ready}, 64'd0);
    exp_q.delete();
    rd_resp_ready = 1'b1;
    release_reset();
    check_init();
    @(posedge clock); #1;
    rd_wr(1, 8'h40, 24'h000000, 0, 8'h00, 24'h0, 4'h0);
    drain();

    // Test 6: random traffic against the reference model
    auto_exp = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rd_req_valid  = ($urandom_range(0, 99) < 60);
      rd_req_addr   = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      wr_req_valid  = ($urandom_range(0, 99) < 50);
      wr_req_addr   = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      wr_req_data   = 24'($urandom());
      wr_req_mask   = 4'($urandom_range(0, 15));
      rd_resp_ready = ($urandom_range(0, 99) < 70);
      @(posedge clock); #1;
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0; rd_resp_ready = 1'b1;
    drain();
    auto_exp = 1'b0;

    // Test 5b: reset mid-INIT at init_ptr=100
    reset_n = 1'b0;
    exp_q.delete();
    release_reset();
    b = 0;
    while (!(mem_W0_en && mem_W0_addr == 8'd100) && b < 300) begin @(posedge clock); #1; b++; end
    chk("reached_ptr_100", {63'd0, mem_W0_en && mem_W0_addr == 8'd100}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("w0_en_in_reset", {63'd0, mem_W0_en}, 64'd0);
    chk("init_done_in_reset", {63'd0, init_done}, 64'd0);
    release_reset();
    check_init();
    @(posedge clock); #1;
    rd_wr(1, 8'h12, 24'h000000, 0, 8'h00, 24'h0, 4'h0);
    rd_wr(1, 8'h84, 24'h000000, 0, 8'h00, 24'h0, 4'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
